// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the LEGv8 control sequencer (states, PS/FS, opcodes, conds, control-word layout).
package ctrl_pkg;
    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_LDWB, S_HALT, S_ERR} state_t;
    typedef enum logic [1:0] {N_FETCH, N_LDWB, N_HALT, N_ERR} nxt_t;
    localparam logic [1:0] PS_HOLD = 2'b00, PS_INC = 2'b01, PS_LOAD = 2'b10;
    localparam logic [4:0] FS_AND = 5'b00000, FS_ORR = 5'b00100, FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001, FS_EOR = 5'b01100, FS_PASSB = 5'b10100;
    localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_EOR = 11'b11001010000, OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000, OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000, OP_BR = 11'b11010110000;
    localparam logic [9:0] OP_ADDI = 10'b1001000100, OP_SUBI = 10'b1101000100;
    localparam logic [7:0] OP_CBZ = 8'b10110100, OP_CBNZ = 8'b10110101, OP_BCOND = 8'b01010100;
    localparam logic [5:0] OP_B = 6'b000101;
    localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_HS = 4'h2, C_LO = 4'h3, C_MI = 4'h4;
    localparam logic [3:0] C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7, C_HI = 4'h8, C_LS = 4'h9;
    localparam logic [3:0] C_GE = 4'hA, C_LT = 4'hB, C_GT = 4'hC, C_LE = 4'hD;
    localparam int CW_PS = 30, CW_DA = 25, CW_SA = 20, CW_SB = 15, CW_FS = 10;
    localparam int CW_REGW = 9, CW_RAMW = 8, CW_EN_MEM = 7, CW_EN_ALU = 6, CW_EN_B = 5;
    localparam int CW_EN_PC = 4, CW_SELB = 3, CW_PCSEL = 2, CW_SL = 1;

    // f is {V,C,N,Z}; 1110 and 1111 both mean always
    function automatic logic cond_met(input logic [3:0] c, input logic [3:0] f);
        logic v, cf, n, z;
        {v, cf, n, z} = f;
        case (c)
            C_EQ: return z;
            C_NE: return !z;
            C_HS: return cf;
            C_LO: return !cf;
            C_MI: return n;
            C_PL: return !n;
            C_VS: return v;
            C_VC: return !v;
            C_HI: return cf && !z;
            C_LS: return !(cf && !z);
            C_GE: return n == v;
            C_LT: return n != v;
            C_GT: return !z && (n == v);
            C_LE: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction
endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational decode of IR into control word, K and next-state class.
// CTRL_BCOND_EN adds ADDS/SUBS (flag-setting) and B.cond; otherwise they decode as illegal.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0] ir,
    input  logic [2:0]  state,
    input  logic [3:0]  flags,
    input  logic [3:0]  status,
    output logic [31:0] cw,
    output logic [63:0] k,
    output logic [1:0]  nxt
);
    logic [10:0] op11;
    logic [4:0] rd, rn, rm, r_fs;
    logic [63:0] k_mem, k_cb, k_b;
    logic is_flagset, is_bcond, is_r, is_imm, unused;
    assign op11 = ir[31:21];
    assign rd = ir[4:0];
    assign rn = ir[9:5];
    assign rm = ir[20:16];
    assign k_mem = {{55{ir[20]}}, ir[20:12]};
    assign k_cb = {{45{ir[23]}}, ir[23:5]};
    assign k_b = {{38{ir[25]}}, ir[25:0]};
`ifdef CTRL_BCOND_EN
    assign is_flagset = op11 == OP_ADDS || op11 == OP_SUBS;
    assign is_bcond = ir[31:24] == OP_BCOND;
    assign unused = ^status[3:1];
`else
    assign is_flagset = 1'b0;
    assign is_bcond = 1'b0;
    assign unused = ^{flags, status[3:1]};
`endif
    assign is_r = op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND || op11 == OP_ORR
                  || op11 == OP_EOR || is_flagset;
    assign is_imm = ir[31:22] == OP_ADDI || ir[31:22] == OP_SUBI;
    assign r_fs = (op11 == OP_SUB || op11 == OP_SUBS) ? FS_SUB : op11 == OP_AND ? FS_AND :
                  op11 == OP_ORR ? FS_ORR : op11 == OP_EOR ? FS_EOR : FS_ADD;
    always_comb begin
        cw = '0;
        k = '0;
        nxt = N_FETCH;
        cw[CW_EN_PC] = state == S_EXEC || state == S_LDWB;
        if (state == S_LDWB) begin
            cw[CW_FS +: 5] = FS_ADD;
            cw[CW_SA +: 5] = rn;
            cw[CW_SELB] = 1'b1;
            k = k_mem;
            cw[CW_EN_MEM] = 1'b1;
            cw[CW_REGW] = 1'b1;
            cw[CW_DA +: 5] = rd;
            cw[CW_PS +: 2] = PS_INC;
        end else if (state == S_EXEC) begin
            if (ir == 32'h0) nxt = N_HALT;
            else if (is_r || is_imm) begin
                cw[CW_DA +: 5] = rd;
                cw[CW_SA +: 5] = rn;
                cw[CW_SB +: 5] = rm;
                cw[CW_FS +: 5] = is_imm ? (ir[30] ? FS_SUB : FS_ADD) : r_fs;
                cw[CW_EN_ALU] = 1'b1;
                cw[CW_EN_B] = 1'b1;
                cw[CW_REGW] = 1'b1;
                cw[CW_SELB] = is_imm;
                cw[CW_SL] = is_flagset;
                cw[CW_PS +: 2] = PS_INC;
                k = is_imm ? {52'b0, ir[21:10]} : 64'b0;
            end else if (op11 == OP_LDUR || op11 == OP_STUR) begin
                cw[CW_FS +: 5] = FS_ADD;
                cw[CW_SA +: 5] = rn;
                cw[CW_SELB] = 1'b1;
                k = k_mem;
                cw[CW_EN_ALU] = op11 == OP_LDUR;
                cw[CW_SB +: 5] = op11 == OP_STUR ? rd : 5'd0;
                cw[CW_EN_B] = op11 == OP_STUR;
                cw[CW_RAMW] = op11 == OP_STUR;
                cw[CW_PS +: 2] = op11 == OP_STUR ? PS_INC : PS_HOLD;
                nxt = op11 == OP_LDUR ? N_LDWB : N_FETCH;
            end else if (ir[31:26] == OP_B) begin
                k = k_b;
                cw[CW_PS +: 2] = PS_LOAD;
            end else if (ir[31:24] == OP_CBZ || ir[31:24] == OP_CBNZ) begin
                cw[CW_SB +: 5] = rd;
                cw[CW_FS +: 5] = FS_PASSB;
                cw[CW_EN_B] = 1'b1;
                k = k_cb;
                // bit 24 distinguishes CBNZ, inverting the sense of Z
                cw[CW_PS +: 2] = (status[0] ^ ir[24]) ? PS_LOAD : PS_INC;
            end else if (is_bcond) begin
                k = k_cb;
                cw[CW_PS +: 2] = cond_met(ir[3:0], flags) ? PS_LOAD : PS_INC;
            end else if (op11 == OP_BR) begin
                cw[CW_SA +: 5] = rn;
                cw[CW_PCSEL] = 1'b1;
                cw[CW_PS +: 2] = PS_LOAD;
            end else nxt = N_ERR;
        end
        cw[CW_REGW] = cw[CW_REGW] && cw[CW_DA +: 5] != 5'd31;
    end
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle LEGv8 control unit holding state, IR, sticky status and the optional
// flag latch (present only with CTRL_BCOND_EN).
module ctrl_sequencer
    import ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] instruction,
    input  logic [3:0]  status,
    output logic [31:0] controlWord,
    output logic [63:0] k,
    output logic        halted,
    output logic        illegal
);
    state_t state, next;
    logic [31:0] ir;
    logic [3:0] flags;
    logic [1:0] nxt;
    ctrl_decoder u_dec (
        .ir(ir), .state(state), .flags(flags), .status(status),
        .cw(controlWord), .k(k), .nxt(nxt)
    );
    assign next = state == S_FETCH ? (run ? S_EXEC : S_FETCH) :
                  state == S_LDWB ? S_FETCH :
                  state != S_EXEC ? state :
                  nxt == N_LDWB ? S_LDWB : nxt == N_HALT ? S_HALT : nxt == N_ERR ? S_ERR : S_FETCH;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
            ir <= '0;
            halted <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= next;
            if (state == S_FETCH && run) ir <= instruction;
            halted <= halted || next == S_HALT;
            illegal <= illegal || next == S_ERR;
        end
    end
`ifdef CTRL_BCOND_EN
    always_ff @(posedge clock) begin
        if (reset) flags <= '0;
        else if (state == S_EXEC && controlWord[CW_SL]) flags <= status;
    end
`else
    assign flags = 4'b0;
`endif
endmodule
